// File: rtl/rf_pkg.sv
// Shared register-file definitions.
// Widths, zero constant and master FSM encoding.
package rf_pkg;

  localparam int REG_SIZE   = 32;
  localparam int INDEX_SIZE = 5;

  localparam logic [REG_SIZE-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rf_timeout_ctr.sv
// WAIT-cycle counter for the register-file access master.
// expired fires during the LIMIT-th enabled cycle.
module rf_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc;

  // next count; stops advancing once the limit is hit
  always_comb begin
    cnt_inc = cnt_q + W'(1);
    expired = en && (cnt_inc == W'(LIMIT));
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_inc;
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_access_master.sv
// Register-file access master: start/finish sequencing,
// operand capture and timeout guard.
module rf_access_master
  import rf_pkg::*;
#(
  parameter int REG_SIZE       = 32,
  parameter int INDEX_SIZE     = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_SIZE-1:0] req_rs,
  input  logic [INDEX_SIZE-1:0] req_rt,
  input  logic                  req_we,
  input  logic [INDEX_SIZE-1:0] req_wa,
  input  logic [REG_SIZE-1:0]   req_wd,
  output logic                  rf_start,
  output logic                  rf_read_enabled,
  output logic [INDEX_SIZE-1:0] rf_read_addr_s,
  output logic [INDEX_SIZE-1:0] rf_read_addr_t,
  output logic                  rf_write_enabled,
  output logic [INDEX_SIZE-1:0] rf_write_addr,
  output logic [REG_SIZE-1:0]   rf_write_data,
  input  logic                  rf_finish,
  input  logic [REG_SIZE-1:0]   rf_outA,
  input  logic [REG_SIZE-1:0]   rf_outB,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_SIZE-1:0]   rsp_a,
  output logic [REG_SIZE-1:0]   rsp_b,
  output logic                  rsp_err,
  output logic [15:0]           access_count
);

  state_e state_q, state_d;

  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [INDEX_SIZE-1:0] rs_q, rs_d;
  logic [INDEX_SIZE-1:0] rt_q, rt_d;
  logic [INDEX_SIZE-1:0] wa_q, wa_d;
  logic [REG_SIZE-1:0]   wd_q, wd_d;
  logic [REG_SIZE-1:0]   a_q, a_d;
  logic [REG_SIZE-1:0]   b_q, b_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  logic to_clr;
  logic to_en;
  logic to_expired;

  rf_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // next-state, request capture and response capture
  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    to_clr  = 1'b0;
    to_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          rs_d    = req_rs;
          rt_d    = req_rt;
          wa_d    = req_wa;
          wd_d    = req_wd;
          rd_en_d = 1'b1;
          // r0 is hardwired to zero in the file
          wr_en_d = req_we && (req_wa != '0);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        to_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        to_en = 1'b1;
        if (rf_finish) begin
          a_d     = rf_outA;
          b_d     = rf_outB;
          err_d   = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = RESP;
        end else if (to_expired) begin
          a_d     = '0;
          b_d     = '0;
          err_d   = 1'b1;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign rf_start         = (state_q == ISSUE);
  assign rsp_valid        = (state_q == RESP);
  assign rf_read_enabled  = rd_en_q;
  assign rf_read_addr_s   = rs_q;
  assign rf_read_addr_t   = rt_q;
  assign rf_write_enabled = wr_en_q;
  assign rf_write_addr    = wa_q;
  assign rf_write_data    = wd_q;
  assign rsp_a            = a_q;
  assign rsp_b            = b_q;
  assign rsp_err          = err_q;
  assign access_count     = cnt_q;

endmodule
